// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR write-back path.
package gpr_pkg;

    localparam int NREG = 32;
    localparam int XLEN = 32;
    localparam int RIDX = 5;

    // Write-back requesters sharing the single GPR write port.
    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // One write-back request: destination index and payload.
    typedef struct packed {
        logic [RIDX-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when an
// instruction that writes rd issues, cleared when the GPR write lands.
// Also produces the RAW/WAW stall seen by decode.
module gpr_scoreboard #(
    parameter int NREG = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            chkValid,
    input  logic            chkWen,
    input  logic [RIDX-1:0] chkRd,
    input  logic [RIDX-1:0] chkRs1,
    input  logic [RIDX-1:0] chkRs2,
    input  logic            clrEn,
    input  logic [RIDX-1:0] clrIdx,
    output logic            stall,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busyQ;
    logic [NREG-1:0] busyNxt;
    logic            setEn;

    // Stall against the current bits only: a register committing this cycle
    // still stalls, there is no bypass from the write stage.
    always_comb begin
        stall = chkValid & (busyQ[chkRs1] | busyQ[chkRs2] | (chkWen & busyQ[chkRd]));
        setEn = chkValid & ~stall & chkWen & (chkRd != '0);
    end

    // Next bitmap: clear the committing index, set the issuing one. They
    // never collide because issue stalls while its rd is still busy.
    always_comb begin
        busyNxt = busyQ;
        if (clrEn)
            busyNxt[clrIdx] = 1'b0;
        if (setEn)
            busyNxt[chkRd] = 1'b1;
        busyNxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            busyQ <= '0;
        else
            busyQ <= busyNxt;
    end

    assign busy = busyQ;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates EXU and LSU write-backs onto the single GPR write port,
// registers the write, and owns the busy scoreboard used for issue stalls.
module gpr_wb_arbiter #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic            iss_wen,
    input  logic [RIDX-1:0] iss_rd,
    input  logic [RIDX-1:0] iss_rs1,
    input  logic [RIDX-1:0] iss_rs2,
    output logic            iss_stall,
    input  logic            exu_valid,
    input  logic [RIDX-1:0] exu_rd,
    input  logic [XLEN-1:0] exu_data,
    output logic            exu_ready,
    input  logic            lsu_valid,
    input  logic [RIDX-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            RegWr,
    output logic [RIDX-1:0] Rw,
    output logic [XLEN-1:0] busW,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    import gpr_pkg::*;

    wb_src_e rrLast;
    wb_req_t exuReq;
    wb_req_t lsuReq;
    wb_req_t selReq;
    logic    grantExu;
    logic    grantLsu;
    logic    accept;
    logic    tie;
    logic    doWrite;

    assign exuReq = '{rd: exu_rd, data: exu_data};
    assign lsuReq = '{rd: lsu_rd, data: lsu_data};

    // Grant: a lone requester always wins; on a tie the one that did not win
    // the previous tie goes. Only ties move the round-robin pointer.
    always_comb begin
        grantExu = 1'b0;
        grantLsu = 1'b0;
        tie      = exu_valid & lsu_valid;
        if (tie) begin
            if (rrLast == WB_LSU)
                grantExu = 1'b1;
            else
                grantLsu = 1'b1;
        end else begin
            grantExu = exu_valid;
            grantLsu = lsu_valid;
        end
        accept  = grantExu | grantLsu;
        selReq  = grantLsu ? lsuReq : exuReq;
        doWrite = accept & (selReq.rd != '0);
    end

    assign exu_ready = grantExu;
    assign lsu_ready = grantLsu;

    // Write stage: one cycle after acceptance the GPR port carries the write.
    // x0 requests are consumed but never drive the port, so Rw/busW keep the
    // last real write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWr  <= 1'b0;
            Rw     <= '0;
            busW   <= '0;
            wb_err <= 1'b0;
            rrLast <= WB_LSU;
        end else begin
            RegWr <= doWrite;
            if (doWrite) begin
                Rw   <= selReq.rd;
                busW <= selReq.data;
                if (!busy[selReq.rd])
                    wb_err <= 1'b1;
            end
            if (tie)
                rrLast <= grantLsu ? WB_LSU : WB_EXU;
        end
    end

    gpr_scoreboard #(
        .NREG (NREG),
        .RIDX (RIDX)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .chkValid (iss_valid),
        .chkWen   (iss_wen),
        .chkRd    (iss_rd),
        .chkRs1   (iss_rs1),
        .chkRs2   (iss_rs2),
        .clrEn    (RegWr),
        .clrIdx   (Rw),
        .stall    (iss_stall),
        .busy     (busy)
    );

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port (RegWr/Rw/busW) between two write-back requesters: EXU (ALU results) and LSU (load data).
- Keeps a 32-entry busy scoreboard of destination registers reserved at issue and not yet written back.
- Gives the decode stage RAW/WAW stall information.
- Sits between IDU/EXU/LSU and the GPR write port; the GPR read ports are unaffected.

Parameters:
- NREG, 32, number of architectural registers (scoreboard depth).
- XLEN, 32, data width.
- RIDX, 5, register index width (log2 NREG).

Ports:
- clk  in  1  clock; also drives GPR WrClk.
- rst_n  in  1  synchronous, active-low reset.
- iss_valid  in  1  decode wants to issue an instruction.
- iss_wen  in  1  the issuing instruction writes rd.
- iss_rd  in  RIDX  destination register.
- iss_rs1  in  RIDX  source register 1.
- iss_rs2  in  RIDX  source register 2.
- iss_stall  out  1  issue must not proceed this cycle (combinational).
- exu_valid  in  1  EXU write-back request.
- exu_rd  in  RIDX  EXU destination register.
- exu_data  in  XLEN  EXU result.
- exu_ready  out  1  EXU request accepted this cycle.
- lsu_valid  in  1  LSU write-back request.
- lsu_rd  in  RIDX  LSU destination register.
- lsu_data  in  XLEN  LSU load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- RegWr  out  1  GPR write enable (registered).
- Rw  out  RIDX  GPR write index (registered).
- busW  out  XLEN  GPR write data (registered).
- busy  out  NREG  scoreboard bitmap, for debug and trace.
- wb_err  out  1  sticky flag: a write-back targeted a register that was not busy.

Behaviour:
- Reset (rst_n low at a posedge): RegWr=0, Rw=0, busW=0, busy=0, wb_err=0, rr_last=LSU (so EXU wins the first tie). Reset mid-operation drops any request in flight; nothing is written.
- Clock and reset naming, and reset polarity/synchronicity, are fixed: one clock clk; reset rst_n is synchronous and active-low.
- Arbitration, combinational within a cycle:
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to rr_last is granted; rr_last updates to the granted requester.
  - ready = grant; the output stage drains every cycle, so there is no backpressure beyond the loss of arbitration.
  - A requester must hold valid, rd and data stable until its ready is seen.
- Write stage: a request accepted in cycle N drives RegWr=1, Rw=rd, busW=data in cycle N+1. The GPR captures it at the end of N+1. Latency is 1 cycle.
- When no request is accepted, RegWr=0 next cycle and Rw/busW hold their previous values.
- rd==0: the request is accepted, but RegWr=0 next cycle. It does not touch busy and does not raise wb_err.
- Scoreboard:
  - Set: busy[iss_rd] is set at the posedge where iss_valid & ~iss_stall & iss_wen & (iss_rd!=0).
  - Clear: busy[Rw] is cleared at the posedge where RegWr=1, the same edge at which the GPR writes.
  - Set and clear never hit the same index: issue stalls while that index is busy.
  - busy[0] is always 0.
- Stall: iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd])).
  - The check uses the current busy bits, so a register being committed this cycle still stalls. This is conservative and there is no bypass.
  - Index 0 never stalls.
- wb_err: set when a request is accepted with rd!=0 and busy[rd]==0. The write is still performed. wb_err clears only on reset.

Decomposition:
- Shared package gpr_pkg: RIDX, XLEN, NREG constants; enum wb_src_e {WB_EXU, WB_LSU}; struct wb_req_t {rd, data}.
- Sub-module gpr_scoreboard: busy bitmap, set/clear logic and stall compare. The arbiter and write stage stay in the top module.

Test Plan:
- Reset with busy forced via prior issues of x5 and x7 -> after a low rst_n edge: busy=0, RegWr=0, wb_err=0.
- Issue rd=x5 -> busy[5]=1. Then exu_valid, rd=5, data=0xDEADBEEF -> next cycle RegWr=1, Rw=5, busW=0xDEADBEEF. busy[5]=0 on the following edge.
- Both valid in the same cycle (exu rd=3, lsu rd=4), both held -> cycle 1 EXU granted, cycle 2 LSU granted. Writes land in order x3 then x4, one per cycle.
- x6 busy, issue with rs1=6 -> iss_stall=1 until the cycle after RegWr for x6; the stall is still 1 during the commit cycle itself.
- Issue with rd=0 and rs1=0, then an EXU write-back to x0 -> no stall, busy unchanged, RegWr stays 0, wb_err=0.
- LSU write-back to x9 while busy[9]=0 -> write performed (Rw=9) and wb_err=1 sticky. Assert rst_n low during a granted request -> next cycle RegWr=0.
